// File: rtl/panel_cmd_capture_pkg.sv
// Shared status codes and FSM state encodings for the front-panel command capture block.
package panel_cmd_capture_pkg;

  // Status codes consumed by the 7-segment decoder.
  typedef enum logic [2:0] {
    TsIdle   = 3'd0,
    TsDone   = 3'd1,
    TsRun    = 3'd2,
    TsSwFull = 3'd3,
    TsSrcAdr = 3'd4,
    TsDstAdr = 3'd5,
    TsData16 = 3'd6
  } status_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSrc  = 3'd1,
    StDst  = 3'd2,
    StDlo  = 3'd3,
    StDhi  = 3'd4,
    StSend = 3'd5,
    StDone = 3'd6
  } state_e;

  function automatic status_e status_of(input state_e st, input logic err);
    status_e code;
    if (err) begin
      code = TsSwFull;
    end else begin
      case (st)
        StIdle:       code = TsIdle;
        StSrc:        code = TsSrcAdr;
        StDst:        code = TsDstAdr;
        StDlo, StDhi: code = TsData16;
        StSend:       code = TsRun;
        StDone:       code = TsDone;
        default:      code = TsIdle;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/panel_cmd_capture_key_debounce.sv
// Enter-key conditioning: 2-flop synchronizer, stability counter and one-clock press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic key_bar,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // The accepted level comes out of reset as "pressed", so a key held through reset
  // must first be seen released before a new press can fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b1;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~key_bar;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        pulse_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/panel_cmd_capture.sv
// Front-panel command entry: steps through src/dst/data capture on debounced enter presses
// and hands the finished command downstream over valid/ready.
module panel_cmd_capture
  import panel_cmd_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        enter_bar,
  input  logic        cancel,
  input  logic [9:0]  sw,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [7:0]  cmd_src,
  output logic [7:0]  cmd_dst,
  output logic [15:0] cmd_data,
  output logic [2:0]  ts,
  output logic [15:0] disp_data
);

  logic enter_pulse;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_debounce (
    .clk    (clk_50M),
    .rst    (rst),
    .key_bar(enter_bar),
    .pulse  (enter_pulse)
  );

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  dst_q, dst_d;
  logic [15:0] data_q, data_d;
  status_e     ts_q;
  logic [15:0] disp_q, disp_d;

  logic range_bad;
  logic capture_st;
  logic capture_ok;

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    valid_d    = valid_q;
    src_d      = src_q;
    dst_d      = dst_q;
    data_d     = data_q;
    range_bad  = (sw[9:8] != 2'b00);
    capture_st = (state_q == StSrc) || (state_q == StDst) ||
                 (state_q == StDlo) || (state_q == StDhi);
    capture_ok = enter_pulse && !range_bad;

    // Once in SEND the command is committed, so cancel no longer applies.
    if (cancel && (state_q != StSend)) begin
      state_d = StIdle;
      err_d   = 1'b0;
      valid_d = 1'b0;
      src_d   = '0;
      dst_d   = '0;
      data_d  = '0;
    end else begin
      if (enter_pulse && capture_st) begin
        err_d = range_bad;
      end
      unique case (state_q)
        StIdle: if (enter_pulse) state_d = StSrc;
        StSrc: begin
          if (capture_ok) begin
            src_d   = sw[7:0];
            state_d = StDst;
          end
        end
        StDst: begin
          if (capture_ok) begin
            dst_d   = sw[7:0];
            state_d = StDlo;
          end
        end
        StDlo: begin
          if (capture_ok) begin
            data_d[7:0] = sw[7:0];
            state_d     = StDhi;
          end
        end
        StDhi: begin
          if (capture_ok) begin
            data_d[15:8] = sw[7:0];
            state_d      = StSend;
            valid_d      = 1'b1;
          end
        end
        StSend: begin
          if (valid_q && cmd_ready) begin
            state_d = StDone;
            valid_d = 1'b0;
          end
        end
        StDone: if (enter_pulse) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    disp_d = '0;
    if (err_q) begin
      disp_d = {6'b0, sw};
    end else begin
      case (state_q)
        StSrc, StDst, StDlo: disp_d = {8'h00, sw[7:0]};
        StDhi:               disp_d = {sw[7:0], data_q[7:0]};
        StSend, StDone:      disp_d = data_q;
        default:             disp_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      ts_q    <= TsIdle;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      ts_q    <= status_of(state_d, err_d);
      disp_q  <= disp_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_src   = src_q;
  assign cmd_dst   = dst_q;
  assign cmd_data  = data_q;
  assign ts        = ts_q;
  assign disp_data = disp_q;

endmodule
